// File: rtl/vga_timing_pkg.sv
// Purpose : shared types and default 640x480@60 timing for the VGA timing generator.
// Latency : n/a (types, constants and a pure helper function only).
// Backpressure: n/a; the display path is free-running and never stalls.
package vga_timing_pkg;

    // Phase of a single scan axis; order matches the scan sequence.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    // 640x480@60 with a 25 MHz pixel clock.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // Counter width for both axes.
    localparam int CNT_W = 10;

    // Total period of one axis (pixels per line or lines per frame).
    function automatic int total_len(input int active, input int front,
                                     input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// Purpose : one scan axis: phase FSM (ACTIVE/FRONT/SYNC/BACK) plus its position counter.
// Latency : phase and count are registered; wrap_out is combinational on the last tick of BACK.
// Backpressure: none; advances on every tick_in, tick_in is the only enable.
//
// Ports:
//   vga_clk  - pixel clock, all state on posedge
//   reset_n  - synchronous active-low reset (phase -> ACTIVE, counters -> 0)
//   tick_in  - advance enable (1 for horizontal, horizontal wrap for vertical)
//   wrap_out - high on the tick that takes count from total-1 back to 0
//   phase    - current phase of this axis
//   count    - current position on this axis, 0..total-1
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int LEN_ACTIVE = H_ACTIVE_DEF,
    parameter int LEN_FRONT  = H_FRONT_DEF,
    parameter int LEN_SYNC   = H_SYNC_DEF,
    parameter int LEN_BACK   = H_BACK_DEF,
    parameter int W          = CNT_W
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    input  logic         tick_in,
    output logic         wrap_out,
    output phase_t       phase,
    output logic [W-1:0] count
);

    // Position of the first count of each phase within the axis.
    localparam logic [W-1:0] BASE_FRONT = W'(LEN_ACTIVE);
    localparam logic [W-1:0] BASE_SYNC  = W'(LEN_ACTIVE + LEN_FRONT);
    localparam logic [W-1:0] BASE_BACK  = W'(LEN_ACTIVE + LEN_FRONT + LEN_SYNC);

    phase_t         phase_q, phase_d;
    logic [W-1:0]   pcnt_q, pcnt_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   last_pcnt;
    logic [W-1:0]   phase_base;
    logic           phase_done;

    // State register.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            phase_q <= ACTIVE;
            pcnt_q  <= '0;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
        end
    end

    // Next state: the phase count reloads on every phase entry, the position
    // counter only reloads when the whole axis wraps.
    always_comb begin
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        if (tick_in) begin
            pcnt_d  = pcnt_q + W'(1);
            count_d = count_q + W'(1);
            if (phase_done) begin
                pcnt_d = '0;
                case (phase_q)
                    ACTIVE:  phase_d = FRONT;
                    FRONT:   phase_d = SYNC;
                    SYNC:    phase_d = BACK;
                    BACK:    phase_d = ACTIVE;
                    default: phase_d = ACTIVE;
                endcase
            end
            if (wrap_out) begin
                count_d = '0;
            end
        end
    end

    // Outputs: per-phase length and base, end-of-phase and axis wrap.
    always_comb begin
        last_pcnt  = W'(LEN_ACTIVE - 1);
        phase_base = '0;
        case (phase_q)
            ACTIVE: begin last_pcnt = W'(LEN_ACTIVE - 1); phase_base = '0;         end
            FRONT:  begin last_pcnt = W'(LEN_FRONT  - 1); phase_base = BASE_FRONT; end
            SYNC:   begin last_pcnt = W'(LEN_SYNC   - 1); phase_base = BASE_SYNC;  end
            BACK:   begin last_pcnt = W'(LEN_BACK   - 1); phase_base = BASE_BACK;  end
            default: begin last_pcnt = W'(LEN_ACTIVE - 1); phase_base = '0;        end
        endcase
        phase_done = tick_in && (pcnt_q == last_pcnt);
        wrap_out   = phase_done && (phase_q == BACK);
    end

    assign phase = phase_q;
    assign count = count_q;

    // Position and phase are tracked redundantly; they must never disagree.
    a_count_matches_phase: assert property (
        @(posedge vga_clk) disable iff (!reset_n) count_q == phase_base + pcnt_q);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : 640x480@60 VGA raster timing: DrawX/DrawY/blank/pulses to renderers, hs/vs to the DAC.
// Latency : DrawX/DrawY/blank/line_start/frame_start 1 cycle after the counters; hs/vs 1+SYNC_DELAY.
// Backpressure: none; free-running raster, downstream must keep up every pixel clock.
//
// Ports:
//   vga_clk     - 25 MHz pixel clock
//   reset_n     - synchronous active-low reset
//   DrawX/DrawY - registered raster position
//   blank       - 1 while the registered position is visible
//   hs/vs       - active-low syncs, delayed SYNC_DELAY cycles behind DrawX/DrawY
//   sync        - composite sync, unused by the DAC, tied low
//   line_start  - one-cycle pulse with DrawX==0
//   frame_start - one-cycle pulse with DrawX==0 and DrawY==0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             blank,
    output logic             hs,
    output logic             vs,
    output logic             sync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    // Stage 0 is the raw sync register; SYNC_DELAY further stages follow it.
    localparam int DL_W    = SYNC_DELAY + 1;

    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_sync_delay
        $error("vga_timing_gen: SYNC_DELAY must be within 0..3");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_totals
        $error("vga_timing_gen: line or frame total does not fit the counters");
    end

    phase_t             h_phase, v_phase;
    logic [CNT_W-1:0]   h_cnt, v_cnt;
    logic               h_wrap, v_wrap;

    logic [CNT_W-1:0]   drawx_q, drawy_q;
    logic               blank_q, line_start_q, frame_start_q;
    logic [DL_W-1:0]    hs_dl_q, vs_dl_q;

    vga_phase_counter #(
        .LEN_ACTIVE (H_ACTIVE),
        .LEN_FRONT  (H_FRONT),
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .W          (CNT_W)
    ) u_h_axis (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .tick_in    (1'b1),
        .wrap_out   (h_wrap),
        .phase      (h_phase),
        .count      (h_cnt)
    );

    // Vertical axis steps once per line, so its wrap lands on the same edge
    // as the horizontal wrap.
    vga_phase_counter #(
        .LEN_ACTIVE (V_ACTIVE),
        .LEN_FRONT  (V_FRONT),
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .W          (CNT_W)
    ) u_v_axis (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .tick_in    (h_wrap),
        .wrap_out   (v_wrap),
        .phase      (v_phase),
        .count      (v_cnt)
    );

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            drawx_q       <= '0;
            drawy_q       <= '0;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_dl_q       <= '1;
            vs_dl_q       <= '1;
        end else begin
            drawx_q       <= h_cnt;
            drawy_q       <= v_cnt;
            blank_q       <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            line_start_q  <= (h_cnt == '0);
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
            // Shift toward the MSB; bit 0 takes the new raw sync level.
            hs_dl_q       <= DL_W'({hs_dl_q, h_phase != SYNC});
            vs_dl_q       <= DL_W'({vs_dl_q, v_phase != SYNC});
        end
    end

    assign DrawX       = drawx_q;
    assign DrawY       = drawy_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hs          = hs_dl_q[SYNC_DELAY];
    assign vs          = vs_dl_q[SYNC_DELAY];
    assign sync        = 1'b0;

    // A frame can only end at the end of a line.
    a_v_wrap_on_h_wrap: assert property (
        @(posedge vga_clk) disable iff (!reset_n) v_wrap |-> h_wrap);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : self-checking bench for vga_timing_gen (reduced raster at delays 0 and 2, full raster at delay 1).
// Latency : expectations pushed at each posedge, popped and compared at the following negedge.
// Backpressure: n/a; fixed-length run.
module tb_vga_timing_gen;

    // Reduced raster so several whole frames fit in a short run.
    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 23
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 11
    // Full 640x480@60 raster.
    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_HT = 800, D_VT = 525;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_blank, a_hs, a_vs, a_sync, a_ls, a_fs;
    logic b_blank, b_hs, b_vs, b_sync, b_ls, b_fs;
    logic c_blank, c_hs, c_vs, c_sync, c_ls, c_fs;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_DELAY(0)
    ) dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y),
        .blank(a_blank), .hs(a_hs), .vs(a_vs), .sync(a_sync),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_DELAY(2)
    ) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y),
        .blank(b_blank), .hs(b_hs), .vs(b_vs), .sync(b_sync),
        .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .SYNC_DELAY(1)
    ) dut_c (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(c_x), .DrawY(c_y),
        .blank(c_blank), .hs(c_hs), .vs(c_vs), .sync(c_sync),
        .line_start(c_ls), .frame_start(c_fs)
    );

    typedef struct {
        bit rst;
        int sx, sy;  bit sblank, sls, sfs, shs0, svs0, shs2, svs2;
        int dx, dy;  bit dblank, dls, dfs, dhs1, dvs1;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: plain position counters, sync decoded from position ranges.
    int       sh = 0, sv = 0, dh = 0, dv = 0;
    bit [3:0] s_hhist = 4'hF, s_vhist = 4'hF, d_hhist = 4'hF, d_vhist = 4'hF;

    initial forever begin
        exp_t e;
        @(posedge vga_clk);
        e.rst = !reset_n;
        if (!reset_n) begin
            sh = 0; sv = 0; dh = 0; dv = 0;
            s_hhist = 4'hF; s_vhist = 4'hF; d_hhist = 4'hF; d_vhist = 4'hF;
            e.sx = 0; e.sy = 0; e.sblank = 0; e.sls = 0; e.sfs = 0;
            e.dx = 0; e.dy = 0; e.dblank = 0; e.dls = 0; e.dfs = 0;
        end else begin
            e.sx = sh; e.sy = sv;
            e.sblank = (sh < S_HA) && (sv < S_VA);
            e.sls = (sh == 0);
            e.sfs = (sh == 0) && (sv == 0);
            s_hhist = {s_hhist[2:0], !(sh >= S_HA + S_HF && sh < S_HA + S_HF + S_HS)};
            s_vhist = {s_vhist[2:0], !(sv >= S_VA + S_VF && sv < S_VA + S_VF + S_VS)};
            e.dx = dh; e.dy = dv;
            e.dblank = (dh < D_HA) && (dv < D_VA);
            e.dls = (dh == 0);
            e.dfs = (dh == 0) && (dv == 0);
            d_hhist = {d_hhist[2:0], !(dh >= D_HA + D_HF && dh < D_HA + D_HF + D_HS)};
            d_vhist = {d_vhist[2:0], !(dv >= D_VA + D_VF && dv < D_VA + D_VF + D_VS)};
            sh++;
            if (sh == S_HT) begin sh = 0; sv++; if (sv == S_VT) sv = 0; end
            dh++;
            if (dh == D_HT) begin dh = 0; dv++; if (dv == D_VT) dv = 0; end
        end
        e.shs0 = s_hhist[0]; e.svs0 = s_vhist[0];
        e.shs2 = s_hhist[2]; e.svs2 = s_vhist[2];
        e.dhs1 = d_hhist[1]; e.dvs1 = d_vhist[1];
        sb.push_back(e);
    end

    // Checker plus independent period/width measurements.
    int last_sfs = -1, last_dls = -1;
    int n_fs_per = 0, n_ls_per = 0, n_hsw = 0, n_blw = 0;
    int hs_run = 0, bl_run = 0;
    bit prev_chs = 1'b1, prev_cbl = 1'b0;

    initial forever begin
        exp_t e;
        @(negedge vga_clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cyc++;
            check_eq("a_DrawX", a_x, e.sx);     check_eq("a_DrawY", a_y, e.sy);
            check_eq("a_blank", a_blank, e.sblank);
            check_eq("a_line_start", a_ls, e.sls);
            check_eq("a_frame_start", a_fs, e.sfs);
            check_eq("a_hs", a_hs, e.shs0);     check_eq("a_vs", a_vs, e.svs0);
            check_eq("a_sync", a_sync, 0);
            check_eq("b_DrawX", b_x, e.sx);     check_eq("b_DrawY", b_y, e.sy);
            check_eq("b_blank", b_blank, e.sblank);
            check_eq("b_frame_start", b_fs, e.sfs);
            check_eq("b_hs", b_hs, e.shs2);     check_eq("b_vs", b_vs, e.svs2);
            check_eq("c_DrawX", c_x, e.dx);     check_eq("c_DrawY", c_y, e.dy);
            check_eq("c_blank", c_blank, e.dblank);
            check_eq("c_line_start", c_ls, e.dls);
            check_eq("c_frame_start", c_fs, e.dfs);
            check_eq("c_hs", c_hs, e.dhs1);     check_eq("c_vs", c_vs, e.dvs1);

            if (e.rst) begin
                last_sfs = -1; last_dls = -1; hs_run = 0; bl_run = 0;
            end else begin
                if (a_fs) begin
                    if (last_sfs >= 0) begin
                        check_eq("a_frame_period", cyc - last_sfs, S_HT * S_VT);
                        n_fs_per++;
                    end
                    last_sfs = cyc;
                end
                if (c_ls) begin
                    if (last_dls >= 0) begin
                        check_eq("c_line_period", cyc - last_dls, D_HT);
                        n_ls_per++;
                    end
                    last_dls = cyc;
                end
                // With one delay stage hs falls alongside DrawX 657, i.e. with the
                // registered colour of pixel 656.
                if (prev_chs && !c_hs) begin
                    check_eq("c_hs_fall_x", c_x, D_HA + D_HF + 1);
                    hs_run = 0;
                end
                if (!c_hs) hs_run++;
                if (!prev_chs && c_hs && hs_run > 0) begin
                    check_eq("c_hs_width", hs_run, D_HS);
                    n_hsw++;
                end
                if (c_blank) bl_run++;
                if (prev_cbl && !c_blank && bl_run > 0) begin
                    check_eq("c_blank_run", bl_run, D_HA);
                    n_blw++;
                end
                if (!c_blank) bl_run = 0;
            end
            prev_chs = c_hs;
            prev_cbl = c_blank;
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (1000) @(negedge vga_clk);
        // Mid-frame, mid-line reset.
        reset_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (1700) @(negedge vga_clk);
        #1;
        check_eq("frame_periods_seen", int'(n_fs_per >= 3), 1);
        check_eq("line_periods_seen",  int'(n_ls_per >= 1), 1);
        check_eq("hs_widths_seen",     int'(n_hsw >= 2), 1);
        check_eq("blank_runs_seen",    int'(n_blw >= 2), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
